// File: rtl/i3c_engine_sched.sv
// i3c_engine_sched: round-robin grant of the shared TX/RX/regfile datapath among SDR (0), DAA (1) and ENTHDR CCC (2) sub-blocks.
//   Optional watchdog: define I3C_SCHED_WATCHDOG_EN to compile in the TIMEOUT_CYCLES watchdog (o_timeout tied 0 otherwise).
//   Inputs : i_clk, i_rst_n (async active-low), i_req/i_done (per sub-block), per-sub-block regfile/TX/RX controls.
//   Outputs: o_en (one-hot grant), muxed regfile/TX/RX controls, o_busy, o_done/o_abort/o_timeout pulses, o_done_id.
module i3c_engine_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_done,
  input  logic [2:0]  i_regf_rd_en,
  input  logic [29:0] i_regf_addr,
  input  logic [2:0]  i_tx_en,
  input  logic [8:0]  i_tx_mode,
  input  logic [2:0]  i_rx_en,
  input  logic [8:0]  i_rx_mode,
  output logic [2:0]  o_en,
  output logic        o_regf_rd_en,
  output logic [9:0]  o_regf_addr,
  output logic        o_tx_en,
  output logic [2:0]  o_tx_mode,
  output logic        o_rx_en,
  output logic [2:0]  o_rx_mode,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_done_id,
  output logic        o_abort,
  output logic        o_timeout
);
  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_e;
  state_e     state_q;
  logic [1:0] sel_q, ptr_q, sel_d, p0, p1, p2;
  logic [2:0] en_q;
  logic       busy_q, done_q, abort_q;
  logic       run, done_hit, abort_hit, wd_hit;
  assign run = state_q == RUN;
  // ptr only ever holds 0..2; a corrupted 3 restarts the scan at 0
  assign p0 = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
  assign p1 = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
  assign p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
  assign sel_d = i_req[p0] ? p0 : i_req[p1] ? p1 : p2;
  assign done_hit  = i_done[sel_q];
  assign abort_hit = ~i_req[sel_q];
  assign o_en         = en_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_abort      = abort_q;
  assign o_done_id    = sel_q;
  assign o_regf_rd_en = run & i_regf_rd_en[sel_q];
  assign o_regf_addr  = run ? i_regf_addr[10*sel_q +: 10] : 10'd0;
  assign o_tx_en      = run & i_tx_en[sel_q];
  assign o_tx_mode    = run ? i_tx_mode[3*sel_q +: 3] : 3'd0;
  assign o_rx_en      = run & i_rx_en[sel_q];
  assign o_rx_mode    = run ? i_rx_mode[3*sel_q +: 3] : 3'd0;
`ifdef I3C_SCHED_WATCHDOG_EN
  logic [9:0] wdog_q;
  assign wd_hit = wdog_q == 10'(TIMEOUT_CYCLES - 1);
  // RELEASE carries exactly one cause, so timeout is the one left when neither done nor abort fired
  assign o_timeout = (state_q == RELEASE) & ~done_q & ~abort_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) wdog_q <= 10'd0;
    else wdog_q <= run ? wdog_q + 10'd1 : 10'd0;
`else
  assign wd_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      en_q    <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: if (|i_req) begin
          state_q <= RUN;
          sel_q   <= sel_d;
          en_q    <= 3'b001 << sel_d;
          busy_q  <= 1'b1;
        end
        RUN: if (done_hit | abort_hit | wd_hit) begin
          state_q <= RELEASE;
          en_q    <= 3'd0;
          ptr_q   <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
          done_q  <= done_hit;
          abort_q <= ~done_hit & abort_hit;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
endmodule
